// File: rtl/riscv_core_dcache_assoc_controller.sv
// N-way set-associative, write-through / write-allocate D-cache controller: tag/valid state,
// parallel hit compare, victim choice, and the refill and store-FIFO handshake sequencing.

module riscv_core_dcache_tag_way #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_W       = 52
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_fill,
  input  logic [INDEX_WIDTH-1:0] i_fill_idx,
  input  logic [TAG_W-1:0]       i_fill_tag,
  input  logic [INDEX_WIDTH-1:0] i_idx,
  input  logic [TAG_W-1:0]       i_tag,
  output logic                   o_valid,
  output logic                   o_hit
);
  localparam int SETS = 2**INDEX_WIDTH;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem [SETS];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) valid_q <= '0;
    else if (i_fill)    valid_q[i_fill_idx] <= 1'b1;
  end

  // Tags need no reset: they are qualified by the valid bit.
  always_ff @(posedge i_clk) begin
    if (i_fill) tag_mem[i_fill_idx] <= i_fill_tag;
  end

  assign o_valid = valid_q[i_idx];
  assign o_hit   = o_valid && (tag_mem[i_idx] == i_tag);
endmodule

module riscv_core_dcache_assoc_controller #(
  parameter int NUM_WAYS         = 2,
  parameter int INDEX_WIDTH      = 7,
  parameter int LINE_BYTES       = 32,
  parameter int ADDR_WIDTH       = 64,
  parameter int CORE_DATA_WIDTH  = 64,
  parameter int FIFO_ENTRY_WIDTH = 128
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_read,
  input  logic                        i_write,
  input  logic [ADDR_WIDTH-1:0]       i_addr_from_core,
  input  logic [CORE_DATA_WIDTH-1:0]  i_data_from_core,
  input  logic                        i_flush,
  output logic                        o_stall,
  output logic                        o_rd_en,
  output logic                        o_wr_en,
  output logic                        o_block_replace,
  output logic [NUM_WAYS-1:0]         o_way_sel,
  output logic [ADDR_WIDTH-1:0]       o_mem_addr,
  output logic                        o_mem_req,
  input  logic                        i_mem_done,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_push,
  output logic [FIFO_ENTRY_WIDTH-1:0] o_fifo_entry
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFF_W;
  localparam int SETS  = 2**INDEX_WIDTH;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, MEM_REQ, REFILL, WAIT_FIFO} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       tag;
    logic [WAY_W-1:0]       way;
    logic                   evict;
  } miss_t;

  state_t                     state_q;
  miss_t                      miss_q;
  logic                       flush_pend_q;
  logic [SETS-1:0][WAY_W-1:0] rr_ptr_q;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic [NUM_WAYS-1:0]    way_valid, way_hit;
  logic [WAY_W-1:0]       victim;
  logic                   all_valid, any_hit, flush_req, fill, clr;

  assign idx       = i_addr_from_core[OFF_W +: INDEX_WIDTH];
  assign tag       = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
  assign any_hit   = |way_hit;
  assign all_valid = &way_valid;
  assign flush_req = i_flush || flush_pend_q;
  assign fill      = (state_q == REFILL) && !i_rst;
  assign clr       = (state_q == IDLE) && flush_req && !i_rst;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    riscv_core_dcache_tag_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_W       (TAG_W)
    ) u_way (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (clr),
      .i_fill     (fill && (miss_q.way == WAY_W'(w))),
      .i_fill_idx (miss_q.idx),
      .i_fill_tag (miss_q.tag),
      .i_idx      (idx),
      .i_tag      (tag),
      .o_valid    (way_valid[w]),
      .o_hit      (way_hit[w])
    );
  end

  // Lowest-index invalid way wins; round-robin pointer only when the set is full.
  always_comb begin
    victim = rr_ptr_q[idx];
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      miss_q       <= '0;
      flush_pend_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_req) begin
            flush_pend_q <= 1'b0;
            rr_ptr_q     <= '0;
          end else if (i_read || i_write) begin
            if (!any_hit) begin
              miss_q  <= '{idx: idx, tag: tag, way: victim, evict: all_valid};
              state_q <= MEM_REQ;
            end else if (!i_read && i_fifo_full) begin
              state_q <= WAIT_FIFO;
            end
          end
        end
        MEM_REQ: begin
          if (i_flush)    flush_pend_q <= 1'b1;
          if (i_mem_done) state_q      <= REFILL;
        end
        REFILL: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (miss_q.evict)
            rr_ptr_q[miss_q.idx] <= (rr_ptr_q[miss_q.idx] == WAY_W'(NUM_WAYS-1)) ?
                                    '0 : rr_ptr_q[miss_q.idx] + WAY_W'(1);
          state_q <= IDLE;
        end
        WAIT_FIFO: begin
          if (i_flush)      flush_pend_q <= 1'b1;
          if (!i_fifo_full) state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_stall         = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_way_sel       = '0;
    o_mem_addr      = '0;
    o_mem_req       = 1'b0;
    o_fifo_push     = 1'b0;
    o_fifo_entry    = '0;
    if (!i_rst) begin
      o_mem_addr = {i_addr_from_core[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      unique case (state_q)
        IDLE: begin
          if (flush_req) begin
            o_stall = 1'b1;
          end else if (i_read) begin
            if (any_hit) begin
              o_rd_en   = 1'b1;
              o_way_sel = way_hit;
            end else begin
              o_stall   = 1'b1;
              o_mem_req = 1'b1;
            end
          end else if (i_write) begin
            if (!any_hit) begin
              o_stall   = 1'b1;
              o_mem_req = 1'b1;
            end else if (i_fifo_full) begin
              o_stall = 1'b1;
            end else begin
              o_wr_en      = 1'b1;
              o_fifo_push  = 1'b1;
              o_way_sel    = way_hit;
              o_fifo_entry = FIFO_ENTRY_WIDTH'({i_addr_from_core, i_data_from_core});
            end
          end
        end
        MEM_REQ: begin
          o_stall   = 1'b1;
          o_mem_req = !i_mem_done;
        end
        REFILL: begin
          o_stall         = 1'b1;
          o_wr_en         = 1'b1;
          o_block_replace = 1'b1;
          o_way_sel       = NUM_WAYS'(1) << miss_q.way;
        end
        WAIT_FIFO: o_stall = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_core_dcache_assoc_controller.sv
// Directed bench: the driver pushes expected refill/completion responses into a queue, a negedge
// monitor pops and compares them; stall and refill-request cycle counts are checked per access.

module tb_riscv_core_dcache_assoc_controller;
  logic         clk = 1'b0;
  logic         rst, rd, wr, flush, mem_done, fifo_full;
  logic [63:0]  addr, data;
  logic         o_stall, o_rd_en, o_wr_en, o_block_replace, o_mem_req, o_fifo_push;
  logic [1:0]   o_way_sel;
  logic [63:0]  o_mem_addr;
  logic [127:0] o_fifo_entry;

  always #5 clk = ~clk;

  riscv_core_dcache_assoc_controller dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_read           (rd),
    .i_write          (wr),
    .i_addr_from_core (addr),
    .i_data_from_core (data),
    .i_flush          (flush),
    .o_stall          (o_stall),
    .o_rd_en          (o_rd_en),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_way_sel        (o_way_sel),
    .o_mem_addr       (o_mem_addr),
    .o_mem_req        (o_mem_req),
    .i_mem_done       (mem_done),
    .i_fifo_full      (fifo_full),
    .o_fifo_push      (o_fifo_push),
    .o_fifo_entry     (o_fifo_entry)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [197:0] exp_q[$];
  logic [197:0] mon_obs;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [63:0] line(input logic [63:0] a);
    return {a[63:5], 5'b0};
  endfunction

  // {block_replace, way_sel, rd_en, wr_en, fifo_push, fifo_entry, mem_addr}
  function automatic logic [197:0] pack(input logic br, input logic [1:0] way, input logic r,
                                        input logic w, input logic push, input logic [127:0] entry,
                                        input logic [63:0] maddr);
    return {br, way, r, w, push, entry, maddr};
  endfunction

  function automatic void exp_refill(input logic [1:0] way, input logic [63:0] a);
    exp_q.push_back(pack(1'b1, way, 1'b0, 1'b1, 1'b0, '0, line(a)));
  endfunction

  function automatic void exp_rd(input logic [1:0] way, input logic [63:0] a);
    exp_q.push_back(pack(1'b0, way, 1'b1, 1'b0, 1'b0, '0, line(a)));
  endfunction

  function automatic void exp_wr(input logic [1:0] way, input logic [63:0] a, input logic [63:0] d);
    exp_q.push_back(pack(1'b0, way, 1'b0, 1'b1, 1'b1, {a, d}, line(a)));
  endfunction

  // Monitor: a refill beat or a completed (unstalled) access is a response.
  always @(negedge clk) begin
    if (!rst && (o_block_replace || ((rd || wr) && !o_stall))) begin
      mon_obs = pack(o_block_replace, o_way_sel, o_rd_en, o_wr_en, o_fifo_push, o_fifo_entry, o_mem_addr);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_response: got %0h expected none", mon_obs);
      end else begin
        check("response", mon_obs, exp_q.pop_front());
      end
    end
  end

  // Holds the request until o_stall drops; answers refill requests after dly request cycles.
  task automatic do_access(input string name, input bit is_wr, input logic [63:0] a,
                           input logic [63:0] d, input int dly, input int full_cyc,
                           input int flush_at, input int exp_stalls, input int exp_mreq);
    int stalls = 0;
    int mreq = 0;
    int run = 0;
    bit go_done;
    bit timeout = 1'b1;
    rd = !is_wr; wr = is_wr; addr = a; data = d;
    fifo_full = (full_cyc > 0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (!o_stall) begin
        timeout = 1'b0;
        break;
      end
      stalls++;
      go_done = 1'b0;
      if (o_mem_req) begin
        mreq++;
        run++;
        check({name, "_mem_addr"}, o_mem_addr, line(a));
        if (run == dly) begin
          go_done = 1'b1;
          run = 0;
        end
      end
      @(posedge clk); #1;
      mem_done  = go_done;
      fifo_full = (stalls < full_cyc);
      flush     = (stalls == flush_at);
    end
    check({name, "_timeout"}, timeout, 0);
    check({name, "_stalls"}, stalls, exp_stalls);
    check({name, "_mreq_cycles"}, mreq, exp_mreq);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; mem_done = 1'b0; flush = 1'b0; fifo_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b1; wr = 1'b0; flush = 1'b0; mem_done = 1'b0; fifo_full = 1'b0;
    addr = 64'h1000; data = 64'h55;
    @(negedge clk);
    check("reset_outputs_zero", {o_stall, o_rd_en, o_wr_en, o_block_replace, o_way_sel, o_mem_addr,
                                 o_mem_req, o_fifo_push, o_fifo_entry}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {o_stall, o_mem_req, o_rd_en, o_wr_en}, '0);
    @(posedge clk); #1;

    // Cold miss: 5 request cycles, a done cycle, one REFILL cycle, then the hit.
    exp_refill(2'b01, 64'h1000); exp_rd(2'b01, 64'h1000);
    do_access("cold_1000", 1'b0, 64'h1000, '0, 5, 0, -1, 7, 5);
    exp_refill(2'b10, 64'h2000); exp_rd(2'b10, 64'h2000);
    do_access("cold_2000", 1'b0, 64'h2000, '0, 3, 0, -1, 5, 3);
    exp_rd(2'b01, 64'h1000);
    do_access("hit_1000", 1'b0, 64'h1000, '0, 2, 0, -1, 0, 0);
    exp_rd(2'b10, 64'h2000);
    do_access("hit_2000", 1'b0, 64'h2000, '0, 2, 0, -1, 0, 0);

    // Full set: round-robin 0 -> way0, 1 -> way1, wraps back to way0.
    exp_refill(2'b01, 64'h3000); exp_rd(2'b01, 64'h3000);
    do_access("evict_3000", 1'b0, 64'h3000, '0, 2, 0, -1, 4, 2);
    exp_refill(2'b10, 64'h1000); exp_rd(2'b10, 64'h1000);
    do_access("evict_1000", 1'b0, 64'h1000, '0, 2, 0, -1, 4, 2);
    exp_refill(2'b01, 64'h2000); exp_rd(2'b01, 64'h2000);
    do_access("evict_2000", 1'b0, 64'h2000, '0, 2, 0, -1, 4, 2);

    // FIFO full for 3 cycles: IDLE + 2 WAIT_FIFO full cycles + 1 WAIT_FIFO exit cycle stall.
    exp_wr(2'b10, 64'h1008, 64'hDEAD);
    do_access("wr_fifo_full", 1'b1, 64'h1008, 64'hDEAD, 2, 3, -1, 4, 0);
    exp_wr(2'b01, 64'h2010, 64'hBEEF);
    do_access("wr_hit", 1'b1, 64'h2010, 64'hBEEF, 2, 0, -1, 0, 0);
    exp_refill(2'b10, 64'h7000); exp_wr(2'b10, 64'h7000, 64'h1234);
    do_access("wr_miss", 1'b1, 64'h7000, 64'h1234, 2, 0, -1, 4, 2);

    // Flush during MEM_REQ: refill finishes, flush runs, the held read misses again.
    exp_refill(2'b01, 64'h5020); exp_refill(2'b01, 64'h5020); exp_rd(2'b01, 64'h5020);
    do_access("flush_mid_refill", 1'b0, 64'h5020, '0, 3, 0, 2, 11, 6);
    exp_refill(2'b01, 64'h2000); exp_rd(2'b01, 64'h2000);
    do_access("post_flush_2000", 1'b0, 64'h2000, '0, 2, 0, -1, 4, 2);

    // Stray i_mem_done while idle must not start a refill.
    mem_done = 1'b1;
    @(posedge clk); #1;
    mem_done = 1'b0;
    @(negedge clk);
    check("stray_done_ignored", {o_stall, o_wr_en, o_block_replace}, 3'b000);
    @(posedge clk); #1;
    exp_rd(2'b01, 64'h2000);
    do_access("hit_after_stray", 1'b0, 64'h2000, '0, 2, 0, -1, 0, 0);

    // Reset while in MEM_REQ abandons the refill and clears all tags.
    rd = 1'b1; addr = 64'h6040;
    @(negedge clk);
    check("rst_idle_miss_req", o_mem_req, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_memreq_state", {o_stall, o_mem_req}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1; rd = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs_zero", {o_stall, o_rd_en, o_wr_en, o_block_replace, o_way_sel,
                                   o_mem_req, o_fifo_push}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {o_stall, o_mem_req}, 2'b00);
    @(posedge clk); #1;
    exp_refill(2'b01, 64'h1000); exp_rd(2'b01, 64'h1000);
    do_access("post_rst_1000", 1'b0, 64'h1000, '0, 2, 0, -1, 4, 2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
